// File: rtl/memwb_skid_stage.sv
// rtl/memwb_skid_stage.sv - MEM/WB pipeline stage with 2-entry skid buffer, flush, x0 gate and stall counter
module memwb_skid_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_ADDR_W    = 5,
    parameter int ZERO_REG_GATE = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     Read_data_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic [DATA_W-1:0]     addr_o,
    output logic [DATA_W-1:0]     Read_data_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0]     fwd_data_o,
    output logic                  fwd_valid_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef struct packed {
        logic                  rw;
        logic                  m2r;
        logic [DATA_W-1:0]     addr;
        logic [DATA_W-1:0]     rdata;
        logic [REG_ADDR_W-1:0] rd;
    } bundle_t;

    // State bits are {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t     state, state_nx;
    bundle_t    in_b, main_q, skid_q;
    logic       main_valid, skid_valid, accept, consume;
    logic       load_main_in, load_main_skid, load_skid;
    logic [CNT_W-1:0] stall_cnt;

    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_ready_o = ~skid_valid;
    assign accept     = in_valid_i & ~skid_valid;
    assign consume    = main_valid & out_ready_i;
    assign in_b       = '{rw: RegWrite_i, m2r: MemtoReg_i, addr: addr_i,
                          rdata: Read_data_i, rd: rd_i};

    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nx     = ONE;
                end
            end
            ONE: begin
                if (accept && !consume) begin
                    load_skid = 1'b1;
                    state_nx  = TWO;
                end else if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (consume) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    load_main_skid = 1'b1;
                    state_nx       = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
        if (flush_i) begin
            state_nx = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Flush keeps stale data but must drop the writeback enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            main_q.rw <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_q <= in_b;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_b;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (in_valid_i && skid_valid && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid_o = main_valid;
    assign RegWrite_o  = (ZERO_REG_GATE != 0) ? (main_q.rw & (|main_q.rd)) : main_q.rw;
    assign MemtoReg_o  = main_q.m2r;
    assign addr_o      = main_q.addr;
    assign Read_data_o = main_q.rdata;
    assign rd_o        = main_q.rd;
    assign fwd_data_o  = main_q.m2r ? main_q.rdata : main_q.addr;
    assign fwd_valid_o = main_valid & RegWrite_o;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// tb/tb_memwb_skid_stage.sv - self-checking bench for memwb_skid_stage against a queue model
module tb_memwb_skid_stage;

    localparam int DATA_W = 32;
    localparam int RW     = 5;
    localparam int CNT_W  = 2;
    localparam int SMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, rw_i, m2r_i, flush, out_valid, out_ready;
    logic [DATA_W-1:0] addr_i, rdata_i, addr_o, rdata_o, fwd_data;
    logic [RW-1:0]     rd_i, rd_o;
    logic              rw_o, m2r_o, fwd_valid;
    logic [CNT_W-1:0]  stall;

    memwb_skid_stage #(.DATA_W(DATA_W), .REG_ADDR_W(RW), .ZERO_REG_GATE(1), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .RegWrite_i(rw_i), .MemtoReg_i(m2r_i), .addr_i(addr_i), .Read_data_i(rdata_i),
        .rd_i(rd_i), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .RegWrite_o(rw_o), .MemtoReg_o(m2r_o), .addr_o(addr_o), .Read_data_o(rdata_o),
        .rd_o(rd_o), .fwd_data_o(fwd_data), .fwd_valid_o(fwd_valid), .stall_cnt_o(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rw;
        logic              m2r;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
        logic [RW-1:0]     rd;
    } bun_t;

    bun_t q[$];
    int   m_stall = 0;
    bit   m_rw_zero = 1'b1;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of at most two bundles, evaluated with the inputs of the coming edge.
    task automatic model_edge();
        bit   ready;
        bun_t b;
        if (rst) begin
            q.delete();
            m_stall   = 0;
            m_rw_zero = 1'b1;
        end else begin
            ready = (q.size() < 2);
            if (in_valid && !ready && m_stall < SMAX) m_stall++;
            if (flush) begin
                q.delete();
                m_rw_zero = 1'b1;
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && ready) begin
                    b = '{rw: rw_i, m2r: m2r_i, addr: addr_i, rdata: rdata_i, rd: rd_i};
                    q.push_back(b);
                end
                if (q.size() > 0) m_rw_zero = 1'b0;
            end
        end
    endtask

    task automatic compare();
        bun_t h;
        logic erw;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("stall_cnt", stall, m_stall);
        if (q.size() > 0) begin
            h   = q[0];
            erw = h.rw & (h.rd != 0);
            chk("RegWrite_o", rw_o, erw);
            chk("MemtoReg_o", m2r_o, h.m2r);
            chk("addr_o", addr_o, h.addr);
            chk("Read_data_o", rdata_o, h.rdata);
            chk("rd_o", rd_o, h.rd);
            chk("fwd_data", fwd_data, h.m2r ? h.rdata : h.addr);
            chk("fwd_valid", fwd_valid, erw);
        end else begin
            chk("fwd_valid_idle", fwd_valid, 1'b0);
            if (m_rw_zero) chk("RegWrite_o_cleared", rw_o, 1'b0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] a);
        in_valid = v;
        addr_i   = a;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rw_i = 1'b1; m2r_i = 1'b0; flush = 1'b0;
        out_ready = 1'b1; addr_i = '0; rdata_i = 32'h55; rd_i = 5'd3;
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_stall", stall, 2'd0);
        rst = 1'b0;

        // Streaming at full rate
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'(i * 16));
            step();
            chk("stream_addr", addr_o, 64'(i * 16));
            chk("stream_ready", in_ready, 1'b1);
        end
        drive(1'b0, '0);
        step();

        // Back-pressure: A, B fill, C blocked
        out_ready = 1'b0;
        drive(1'b1, 32'h100); step();
        drive(1'b1, 32'h200); step();
        chk("bp_ready_low", in_ready, 1'b0);
        drive(1'b1, 32'h300); step();
        chk("bp_stall1", stall, 2'd1);
        step();
        chk("bp_stall2", stall, 2'd2);
        chk("bp_head_A", addr_o, 32'h100);
        out_ready = 1'b1;
        step();
        chk("bp_head_B", addr_o, 32'h200);
        step();
        chk("bp_head_C", addr_o, 32'h300);
        drive(1'b0, '0);
        step();

        // x0 write suppression
        rw_i = 1'b1; rd_i = 5'd0;
        drive(1'b1, 32'h40); step();
        chk("x0_regwrite", rw_o, 1'b0);
        chk("x0_fwd_valid", fwd_valid, 1'b0);
        rd_i = 5'd5;
        drive(1'b1, 32'h44); step();
        chk("x5_regwrite", rw_o, 1'b1);

        // Forwarding mux
        m2r_i = 1'b1; rdata_i = 32'hDEADBEEF;
        drive(1'b1, 32'h4); step();
        chk("fwd_read_data", fwd_data, 32'hDEADBEEF);
        m2r_i = 1'b0;
        step();
        chk("fwd_addr", fwd_data, 32'h4);
        drive(1'b0, '0); step();

        // Flush while full with a concurrent offer
        out_ready = 1'b0;
        drive(1'b1, 32'h500); step();
        drive(1'b1, 32'h600); step();
        drive(1'b1, 32'hBAD); flush = 1'b1; step();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_regwrite", rw_o, 1'b0);
        flush = 1'b0; drive(1'b0, '0); out_ready = 1'b1;
        repeat (3) step();

        // Saturation, then reset while full
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h700); step();
        drive(1'b1, 32'h800); step();
        repeat (6) step();
        chk("sat_stall", stall, 2'd3);
        rst = 1'b1; step();
        chk("rst_full_valid", out_valid, 1'b0);
        chk("rst_full_ready", in_ready, 1'b1);
        chk("rst_full_stall", stall, 2'd0);
        chk("rst_full_rw", rw_o, 1'b0);
        chk("rst_full_m2r", m2r_o, 1'b0);
        chk("rst_full_rdata", rdata_o, 32'h0);
        chk("rst_full_rd", rd_o, 5'd0);
        rst = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            rw_i      = $urandom_range(0, 1);
            m2r_i     = $urandom_range(0, 1);
            addr_i    = $urandom;
            rdata_i   = $urandom;
            rd_i      = RW'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
